// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the MEM stage (priority) and a debug master.
// Build option: define DMEM_ARB_DBG_WRITE_EN to let debug writes reach memory; otherwise debug is read-only.
module dmem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_cpu_req,
   input  logic                i_cpu_we,
   input  logic [ADDR_W-1:0]   i_cpu_addr,
   input  logic [XLEN-1:0]     i_cpu_wdata,
   input  logic [XLEN/8-1:0]   i_cpu_be,
   output logic                o_cpu_stall,
   output logic                o_cpu_rvalid,
   output logic [XLEN-1:0]     o_cpu_rdata,
   input  logic                i_dbg_req,
   input  logic                i_dbg_we,
   input  logic [ADDR_W-1:0]   i_dbg_addr,
   input  logic [XLEN-1:0]     i_dbg_wdata,
   output logic                o_dbg_gnt,
   output logic                o_dbg_rvalid,
   output logic [XLEN-1:0]     o_dbg_rdata,
   output logic                o_dbg_err,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [XLEN-1:0]     o_mem_wdata,
   output logic [XLEN/8-1:0]   o_mem_be,
   input  logic [XLEN-1:0]     i_mem_rdata
);

   localparam int BE_W  = XLEN / 8;
   // A zero limit still needs a 1-bit counter; it simply never leaves zero.
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DBG = 1'b1;

`ifdef DMEM_ARB_DBG_WRITE_EN
   localparam logic DBG_WRITE_OK = 1'b1;
`else
   localparam logic DBG_WRITE_OK = 1'b0;
`endif

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             pending_q, pending_d;
   logic             tag_q, tag_d;
   logic             dbg_err_q, dbg_err_d;
   logic [XLEN-1:0]  cpu_rdata_q, cpu_rdata_d;
   logic [XLEN-1:0]  dbg_rdata_q, dbg_rdata_d;

   logic dbg_win;
   logic dbg_wr_block;
   logic rd_accept;

   always_comb begin
      dbg_win      = i_dbg_req & (~i_cpu_req | (wait_cnt_q == LIMIT));
      dbg_wr_block = dbg_win & i_dbg_we & ~DBG_WRITE_OK;
      o_dbg_gnt    = dbg_win;
      o_cpu_stall  = i_cpu_req & dbg_win;
   end

   // A rejected debug write is granted but must not touch memory.
   always_comb begin
      o_mem_en = (i_cpu_req | i_dbg_req) & ~dbg_wr_block;
      if (dbg_win) begin
         o_mem_we    = i_dbg_we & DBG_WRITE_OK;
         o_mem_addr  = i_dbg_addr;
         o_mem_wdata = i_dbg_wdata;
         o_mem_be    = {BE_W{1'b1}};
      end else begin
         o_mem_we    = i_cpu_we;
         o_mem_addr  = i_cpu_addr;
         o_mem_wdata = i_cpu_wdata;
         o_mem_be    = i_cpu_be;
      end
      rd_accept = o_mem_en & ~o_mem_we;
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!i_dbg_req || dbg_win) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != LIMIT) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      pending_d = rd_accept;
      tag_d     = tag_q;
      if (rd_accept) begin
         tag_d = dbg_win ? OWNER_DBG : OWNER_CPU;
      end
      dbg_err_d = dbg_wr_block;
   end

   // Returning read data goes straight to its owner; the other side keeps its last value.
   always_comb begin
      o_cpu_rvalid = pending_q & (tag_q == OWNER_CPU);
      o_dbg_rvalid = pending_q & (tag_q == OWNER_DBG);
      cpu_rdata_d  = o_cpu_rvalid ? i_mem_rdata : cpu_rdata_q;
      dbg_rdata_d  = o_dbg_rvalid ? i_mem_rdata : dbg_rdata_q;
      o_cpu_rdata  = cpu_rdata_d;
      o_dbg_rdata  = dbg_rdata_d;
      o_dbg_err    = dbg_err_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wait_cnt_q  <= '0;
         pending_q   <= 1'b0;
         tag_q       <= OWNER_CPU;
         dbg_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         pending_q   <= pending_d;
         tag_q       <= tag_d;
         dbg_err_q   <= dbg_err_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: instance 0 uses a starvation limit of 4, instance 1 a limit of 0.
// A spec-level model checks every cycle at the falling edge; directed checks pin the scenarios.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_DBG_WRITE_EN
   localparam bit WRITE_EN = 1'b1;
`else
   localparam bit WRITE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        cpuReq    [2];
   logic        cpuWe     [2];
   logic [31:0] cpuAddr   [2];
   logic [31:0] cpuWdata  [2];
   logic [3:0]  cpuBe     [2];
   logic        cpuStall  [2];
   logic        cpuRvalid [2];
   logic [31:0] cpuRdata  [2];
   logic        dbgReq    [2];
   logic        dbgWe     [2];
   logic [31:0] dbgAddr   [2];
   logic [31:0] dbgWdata  [2];
   logic        dbgGnt    [2];
   logic        dbgRvalid [2];
   logic [31:0] dbgRdata  [2];
   logic        dbgErr    [2];
   logic        memEn     [2];
   logic        memWe     [2];
   logic [31:0] memAddr   [2];
   logic [31:0] memWdata  [2];
   logic [3:0]  memBe     [2];
   logic [31:0] memRdata  [2];

   bit [31:0] mem [2][256];

   int totalChecks = 0;
   int badChecks   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gDut
      dmem_port_arbiter #(
         .XLEN(32),
         .ADDR_W(32),
         .STARVE_LIMIT((g == 0) ? 4 : 0)
      ) uDut (
         .i_clk(clk),
         .i_rst(rst),
         .i_cpu_req(cpuReq[g]),
         .i_cpu_we(cpuWe[g]),
         .i_cpu_addr(cpuAddr[g]),
         .i_cpu_wdata(cpuWdata[g]),
         .i_cpu_be(cpuBe[g]),
         .o_cpu_stall(cpuStall[g]),
         .o_cpu_rvalid(cpuRvalid[g]),
         .o_cpu_rdata(cpuRdata[g]),
         .i_dbg_req(dbgReq[g]),
         .i_dbg_we(dbgWe[g]),
         .i_dbg_addr(dbgAddr[g]),
         .i_dbg_wdata(dbgWdata[g]),
         .o_dbg_gnt(dbgGnt[g]),
         .o_dbg_rvalid(dbgRvalid[g]),
         .o_dbg_rdata(dbgRdata[g]),
         .o_dbg_err(dbgErr[g]),
         .o_mem_en(memEn[g]),
         .o_mem_we(memWe[g]),
         .o_mem_addr(memAddr[g]),
         .o_mem_wdata(memWdata[g]),
         .o_mem_be(memBe[g]),
         .i_mem_rdata(memRdata[g])
      );
   end

   // Synchronous memory behind each port: byte-enabled writes, one-cycle read latency.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (memEn[k] === 1'b1) begin
            if (memWe[k] === 1'b1) begin
               for (int b = 0; b < 4; b++) begin
                  if (memBe[k][b]) mem[k][memAddr[k][9:2]][8*b +: 8] = memWdata[k][8*b +: 8];
               end
            end else begin
               memRdata[k] <= mem[k][memAddr[k][9:2]];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int k, input bit cReq, input bit cWe, input bit [31:0] cAddr,
                                input bit [31:0] cWd, input bit [3:0] cBe, input bit dReq,
                                input bit dWe, input bit [31:0] dAddr, input bit [31:0] dWd);
      cpuReq[k]   = cReq;
      cpuWe[k]    = cWe;
      cpuAddr[k]  = cAddr;
      cpuWdata[k] = cWd;
      cpuBe[k]    = cBe;
      dbgReq[k]   = dReq;
      dbgWe[k]    = dWe;
      dbgAddr[k]  = dAddr;
      dbgWdata[k] = dWd;
   endtask

   task automatic idleAll();
      for (int k = 0; k < 2; k++) applyStimulus(k, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic atSample();
      @(negedge clk);
   endtask

   // Model state: how long the pending debug request has lost, which master owns the
   // read returning this cycle (0 none, 1 cpu, 2 debug), and the data each master last saw.
   int        limitOf [2] = '{4, 0};
   int        mWait   [2];
   int        mOwner  [2];
   bit [31:0] mData   [2];
   bit [31:0] mLastCpu[2];
   bit [31:0] mLastDbg[2];
   bit        mErr    [2];
   int        nWait   [2];
   int        nOwner  [2];
   bit [31:0] nData   [2];
   bit [31:0] nLastCpu[2];
   bit [31:0] nLastDbg[2];
   bit        nErr    [2];

   always @(negedge clk) begin : modelCompare
      bit win, blocked, expEn, expWe;
      bit [31:0] expAddr, expWdata, expCpuRd, expDbgRd;
      bit [3:0]  expBe;
      for (int k = 0; k < 2; k++) begin
         mWait[k] = nWait[k];
         mOwner[k] = nOwner[k];
         mData[k] = nData[k];
         mLastCpu[k] = nLastCpu[k];
         mLastDbg[k] = nLastDbg[k];
         mErr[k] = nErr[k];
         if (rst) begin
            mWait[k] = 0;
            mOwner[k] = 0;
            mData[k] = 0;
            mLastCpu[k] = 0;
            mLastDbg[k] = 0;
            mErr[k] = 0;
         end

         win      = dbgReq[k] && (!cpuReq[k] || mWait[k] >= limitOf[k]);
         blocked  = win && dbgWe[k] && !WRITE_EN;
         expEn    = (cpuReq[k] || dbgReq[k]) && !blocked;
         expWe    = win ? (dbgWe[k] && WRITE_EN) : cpuWe[k];
         expAddr  = win ? dbgAddr[k] : cpuAddr[k];
         expWdata = win ? dbgWdata[k] : cpuWdata[k];
         expBe    = win ? 4'hF : cpuBe[k];
         expCpuRd = (mOwner[k] == 1) ? mData[k] : mLastCpu[k];
         expDbgRd = (mOwner[k] == 2) ? mData[k] : mLastDbg[k];

         checkOutput($sformatf("m%0d dbg_gnt", k), dbgGnt[k], win);
         checkOutput($sformatf("m%0d cpu_stall", k), cpuStall[k], cpuReq[k] && win);
         checkOutput($sformatf("m%0d mem_en", k), memEn[k], expEn);
         if (expEn || blocked) checkOutput($sformatf("m%0d mem_we", k), memWe[k], expWe);
         if (expEn) begin
            checkOutput($sformatf("m%0d mem_addr", k), memAddr[k], expAddr);
            checkOutput($sformatf("m%0d mem_wdata", k), memWdata[k], expWdata);
            checkOutput($sformatf("m%0d mem_be", k), memBe[k], expBe);
         end
         checkOutput($sformatf("m%0d cpu_rvalid", k), cpuRvalid[k], mOwner[k] == 1);
         checkOutput($sformatf("m%0d dbg_rvalid", k), dbgRvalid[k], mOwner[k] == 2);
         checkOutput($sformatf("m%0d cpu_rdata", k), cpuRdata[k], expCpuRd);
         checkOutput($sformatf("m%0d dbg_rdata", k), dbgRdata[k], expDbgRd);
         checkOutput($sformatf("m%0d dbg_err", k), dbgErr[k], mErr[k]);

         if (dbgReq[k] && !win) nWait[k] = (mWait[k] < limitOf[k]) ? mWait[k] + 1 : limitOf[k];
         else nWait[k] = 0;
         nOwner[k] = (expEn && !expWe) ? (win ? 2 : 1) : 0;
         nData[k] = (expEn && !expWe) ? mem[k][expAddr[9:2]] : 32'h0;
         nLastCpu[k] = expCpuRd;
         nLastDbg[k] = expDbgRd;
         nErr[k] = blocked;
      end
   end

   initial begin
      idleAll();
      for (int k = 0; k < 2; k++) begin
         mem[k][8'h40] = 32'hDEADBEEF;
         mem[k][8'h41] = 32'h12345678;
         mem[k][8'h42] = 32'h55555555;
         mem[k][8'h43] = 32'h11111111;
      end
      repeat (2) atSample();
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("rst cpu_rvalid%0d", k), cpuRvalid[k], 0);
         checkOutput($sformatf("rst dbg_rvalid%0d", k), dbgRvalid[k], 0);
         checkOutput($sformatf("rst dbg_err%0d", k), dbgErr[k], 0);
         checkOutput($sformatf("rst cpu_rdata%0d", k), cpuRdata[k], 0);
         checkOutput($sformatf("rst dbg_rdata%0d", k), dbgRdata[k], 0);
      end
      nextCycle();
      rst = 1'b0;

      // CPU-only load
      nextCycle(); applyStimulus(0, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
      atSample();
      checkOutput("s1 stall", cpuStall[0], 0);
      checkOutput("s1 mem_addr", memAddr[0], 32'h100);
      nextCycle(); idleAll(); atSample();
      checkOutput("s1 cpu_rvalid", cpuRvalid[0], 1);
      checkOutput("s1 cpu_rdata", cpuRdata[0], 32'hDEADBEEF);

      // Debug-only read
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h104, 0);
      atSample();
      checkOutput("s2 gnt", dbgGnt[0], 1);
      checkOutput("s2 mem_addr", memAddr[0], 32'h104);
      nextCycle(); idleAll(); atSample();
      checkOutput("s2 dbg_rvalid", dbgRvalid[0], 1);
      checkOutput("s2 dbg_rdata", dbgRdata[0], 32'h12345678);
      checkOutput("s2 cpu_rvalid", cpuRvalid[0], 0);
      checkOutput("s2 cpu_rdata hold", cpuRdata[0], 32'hDEADBEEF);

      // Starvation with limit 4: debug forced through in cycle 4 only
      for (int i = 0; i < 7; i++) begin
         nextCycle(); applyStimulus(0, 1, 0, 32'h100, 0, 0, i <= 4, 0, 32'h104, 0);
         atSample();
         checkOutput($sformatf("s3 gnt c%0d", i), dbgGnt[0], i == 4);
         checkOutput($sformatf("s3 stall c%0d", i), cpuStall[0], i == 4);
         checkOutput($sformatf("s3 mem_addr c%0d", i), memAddr[0], (i == 4) ? 32'h104 : 32'h100);
         if (i == 5) checkOutput("s3 dbg_rvalid", dbgRvalid[0], 1);
      end
      nextCycle(); idleAll(); atSample();
      checkOutput("s3 last cpu_rvalid", cpuRvalid[0], 1);

      // Limit 0: debug wins at once, CPU stalled one cycle
      nextCycle(); applyStimulus(1, 1, 0, 32'h100, 0, 0, 1, 0, 32'h104, 0);
      atSample();
      checkOutput("s4 gnt", dbgGnt[1], 1);
      checkOutput("s4 stall", cpuStall[1], 1);
      nextCycle(); applyStimulus(1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
      atSample();
      checkOutput("s4 stall released", cpuStall[1], 0);
      checkOutput("s4 dbg_rdata", dbgRdata[1], 32'h12345678);
      nextCycle(); idleAll(); atSample();
      checkOutput("s4 cpu_rvalid", cpuRvalid[1], 1);
      checkOutput("s4 cpu_rdata", cpuRdata[1], 32'hDEADBEEF);

      // Async reset just after a CPU load is accepted, with debug partly starved
      for (int i = 0; i < 3; i++) begin
         nextCycle(); applyStimulus(0, 1, 0, 32'h100, 0, 0, 1, 0, 32'h104, 0);
         atSample();
         checkOutput($sformatf("s5 pre gnt c%0d", i), dbgGnt[0], 0);
      end
      nextCycle(); rst = 1'b1; idleAll();
      atSample();
      checkOutput("s5 cpu_rvalid", cpuRvalid[0], 0);
      checkOutput("s5 cpu_rdata", cpuRdata[0], 0);
      checkOutput("s5 dbg_rdata", dbgRdata[0], 0);
      checkOutput("s5 dbg_err", dbgErr[0], 0);
      nextCycle(); atSample();
      checkOutput("s5 cpu_rvalid later", cpuRvalid[0], 0);
      nextCycle(); rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nextCycle(); applyStimulus(0, 1, 0, 32'h100, 0, 0, 1, 0, 32'h104, 0);
         atSample();
         checkOutput($sformatf("s5 post gnt c%0d", i), dbgGnt[0], i == 4);
      end
      nextCycle(); idleAll();

      // Debug write of 0xAA to 0x108
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h108, 32'h0000_00AA);
      atSample();
      checkOutput("s6 gnt", dbgGnt[0], 1);
      checkOutput("s6 mem_en", memEn[0], WRITE_EN);
      checkOutput("s6 mem_we", memWe[0], WRITE_EN);
      nextCycle(); idleAll(); atSample();
      checkOutput("s6 dbg_err", dbgErr[0], !WRITE_EN);
      checkOutput("s6 dbg_rvalid", dbgRvalid[0], 0);
      nextCycle(); atSample();
      checkOutput("s6 dbg_err cleared", dbgErr[0], 0);
      checkOutput("s6 mem content", mem[0][8'h42], WRITE_EN ? 32'h0000_00AA : 32'h5555_5555);

      // CPU store with partial byte enables
      nextCycle(); applyStimulus(0, 1, 1, 32'h10C, 32'hCAFEF00D, 4'b0011, 0, 0, 0, 0);
      atSample();
      checkOutput("s7 stall", cpuStall[0], 0);
      checkOutput("s7 mem_be", memBe[0], 4'b0011);
      nextCycle(); idleAll(); atSample();
      checkOutput("s7 cpu_rvalid", cpuRvalid[0], 0);
      checkOutput("s7 mem content", mem[0][8'h43], 32'h1111F00D);

      nextCycle();
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
